// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared types and default widths for the register readout serializer
//
// Purpose : holds the readout FSM state encoding and the default word/symbol
//           widths used as parameter defaults by reg_readout_ser and sym_shift_reg.
// Ports   : none (package)

package reg_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int SYM_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sym_shift_reg.sv
// rtl/sym_shift_reg.sv - word capture register that shifts one symbol per enable
//
// Purpose : captures a DATA_W word on load and moves it SYM_W bits toward the
//           output end on each shift, presenting the current symbol combinationally.
// Ports   : clk    - clock, rising edge
//           rst    - synchronous active-low reset, clears the register
//           load   - capture d_in (takes priority over shift)
//           shift  - advance by one symbol
//           d_in   - word to capture
//           sym    - symbol currently at the output end (not gated by valid)

module sym_shift_reg
   import reg_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SYM_W     = SYM_W_DEF,
   parameter int LSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] d_in,
   output logic [SYM_W-1:0]  sym
);

   logic [DATA_W-1:0] sh_q;

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         // Output end is the low symbol; shifting right brings the next one down.
         always_ff @(posedge clk) begin
            if (!rst) begin
               sh_q <= '0;
            end else if (load) begin
               sh_q <= d_in;
            end else if (shift) begin
               sh_q <= sh_q >> SYM_W;
            end
         end
         assign sym = sh_q[SYM_W-1:0];
      end else begin : g_msb
         // Output end is the high symbol; shifting left brings the next one up.
         always_ff @(posedge clk) begin
            if (!rst) begin
               sh_q <= '0;
            end else if (load) begin
               sh_q <= d_in;
            end else if (shift) begin
               sh_q <= sh_q << SYM_W;
            end
         end
         assign sym = sh_q[DATA_W-1 -: SYM_W];
      end
   endgenerate

endmodule

// File: rtl/reg_readout_ser.sv
// rtl/reg_readout_ser.sv - serializes a captured register word into ready/valid symbols
//
// Purpose : on start, captures d_in and emits it as N = DATA_W/SYM_W symbols with
//           valid/ready handshaking, flags the last symbol, pulses done after the
//           final accepted symbol, and supports abort of an in-progress transfer.
// Ports   : clk       - clock, rising edge
//           rst       - synchronous active-low reset
//           start     - capture d_in and begin a transfer (honoured in IDLE only)
//           d_in      - register word to read out
//           abort     - cancel the transfer (honoured in SEND only)
//           sym_ready - downstream accepts sym_out this cycle
//           sym_out   - current symbol, zero when sym_valid is low
//           sym_valid - sym_out holds a valid symbol
//           sym_last  - current symbol is the final one
//           busy      - transfer in progress
//           done      - one-cycle pulse after the final symbol is accepted

module reg_readout_ser
   import reg_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SYM_W     = SYM_W_DEF,
   parameter int LSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] d_in,
   input  logic              abort,
   input  logic              sym_ready,
   output logic [SYM_W-1:0]  sym_out,
   output logic              sym_valid,
   output logic              sym_last,
   output logic              busy,
   output logic              done
);

   localparam int N     = DATA_W / SYM_W;
   // Keep the counter at least one bit wide so a single-symbol word still elaborates.
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             load;
   logic             shift;
   logic             cnt_inc;
   logic             at_last;
   logic [SYM_W-1:0] sym_raw;

   assign at_last = (cnt_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      shift   = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            // Abort wins over a transfer that happens in the same cycle.
            if (abort) begin
               state_d = IDLE;
            end else if (sym_ready) begin
               if (at_last) begin
                  state_d = DONE;
               end else begin
                  shift   = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   sym_shift_reg #(
      .DATA_W    (DATA_W),
      .SYM_W     (SYM_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .d_in  (d_in),
      .sym   (sym_raw)
   );

   assign sym_valid = (state_q == SEND);
   assign sym_last  = sym_valid && at_last;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   // The register keeps stale data after abort/done; gate it so the bus idles at zero.
   assign sym_out   = sym_valid ? sym_raw : '0;

endmodule
